// File: rtl/riscv_pkg.sv
// Shared decode constants and ALU operation encoding
// for the RV32I integer execute core.
package riscv_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

endpackage

// File: rtl/riscv_alu.sv
// Combinational RV32I integer ALU.
// Shift amounts use only the low five bits of operand b.
module riscv_alu
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}},
                                ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/riscv_exec_top.sv
// Single-cycle RV32I OP / OP-IMM execute core with a 32x32
// register file; result is written back and registered on rd.
module riscv_exec_top
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] rd
);

    logic [6:0]       opcode;
    logic [4:0]       rd_idx;
    logic [2:0]       funct3;
    logic [4:0]       rs1_idx;
    logic [4:0]       rs2_idx;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] shamt_ext;

    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rd_d;

    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    alu_op_t          alu_op;
    logic             valid;
    logic             f7_ok;

    assign opcode    = addr[6:0];
    assign rd_idx    = addr[11:7];
    assign funct3    = addr[14:12];
    assign rs1_idx   = addr[19:15];
    assign rs2_idx   = addr[24:20];
    assign funct7    = addr[31:25];
    assign imm       = {{(WIDTH-12){addr[31]}}, addr[31:20]};
    assign shamt_ext = {{(WIDTH-5){1'b0}}, addr[24:20]};

    assign rs1_val = (rs1_idx == 5'd0) ? '0 : regs_q[rs1_idx];
    assign rs2_val = (rs2_idx == 5'd0) ? '0 : regs_q[rs2_idx];

    // The alternate funct7 only exists for SUB and SRA.
    assign f7_ok = (funct7 == F7_BASE) ||
                   ((funct7 == F7_ALT) &&
                    ((funct3 == F3_ADD) || (funct3 == F3_SR)));

    always_comb begin
        alu_op = ALU_ADD;
        op_b   = rs2_val;
        valid  = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                valid = f7_ok;
                op_b  = rs2_val;
            end
            OPC_OPIMM: begin
                valid = 1'b1;
                if ((funct3 == F3_SLL) || (funct3 == F3_SR)) begin
                    op_b = shamt_ext;
                end else begin
                    op_b = imm;
                end
            end
            default: begin
                valid = 1'b0;
            end
        endcase

        unique case (funct3)
            F3_ADD: begin
                if ((opcode == OPC_OP) && funct7[5]) begin
                    alu_op = ALU_SUB;
                end else begin
                    alu_op = ALU_ADD;
                end
            end
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    riscv_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a      (rs1_val),
        .b      (op_b),
        .op     (alu_op),
        .result (alu_res)
    );

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        rd_d = '0;
        if (valid) begin
            rd_d = alu_res;
            if (rd_idx != 5'd0) begin
                regs_d[rd_idx] = alu_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_q <= rd_d;
        end
    end

    assign rd = rd_q;

endmodule

// File: tb/tb_riscv_exec_top.sv
// Directed bench for riscv_exec_top: ALU ops, signed paths,
// x0 protection, illegal encodings and asynchronous reset.
module tb_riscv_exec_top;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] rd;

    int n_tests;
    int n_fail;

    riscv_exec_top #(
        .WIDTH(32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .rd   (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_op(
        input logic [6:0] f7,
        input logic [4:0] rs2,
        input logic [4:0] rs1,
        input logic [2:0] f3,
        input logic [4:0] rdi
    );
        return {f7, rs2, rs1, f3, rdi, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_op(
        input logic [11:0] imm,
        input logic [4:0]  rs1,
        input logic [2:0]  f3,
        input logic [4:0]  rdi
    );
        return {imm, rs1, f3, rdi, 7'b0010011};
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        n_tests++;
        assert (rd === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, rd, exp);
        end
    endtask

    task automatic step(
        input string       tag,
        input logic [31:0] instr,
        input logic [31:0] exp
    );
        @(negedge clk);
        addr = instr;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        addr    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd", 32'h0);
        @(negedge clk);
        rst = 1'b1;

        step("idle0", 32'h0000_0000, 32'h0);
        step("idle1", 32'h0000_0000, 32'h0);

        step("addi_x1", 32'h00A0_8093, 32'd10);
        step("addi_x2", 32'h00A1_0113, 32'd10);
        step("add_x3",  32'h0011_01B3, 32'd20);
        step("slt_x4",  32'h0030_A233, 32'd1);
        step("srli_x5", 32'h0011_5293, 32'd5);
        step("slli_x6", 32'h0021_1313, 32'd40);
        step("and_x7",  32'h0032_F3B3, 32'd4);
        step("or_x8",   32'h0032_E433, 32'd21);
        step("xor_x9",  32'h0032_C4B3, 32'd17);
        step("nop_zero", 32'h0000_0000, 32'h0);
        // Registers survive the illegal word.
        step("read_x9", r_op(7'h00, 5'd0, 5'd9, 3'b000, 5'd16), 32'd17);
        step("read_x6", r_op(7'h00, 5'd0, 5'd6, 3'b110, 5'd16), 32'd40);

        step("addi_neg", 32'hFFF0_0513, 32'hFFFF_FFFF);
        step("srai_x11", i_op({7'h20, 5'd4}, 5'd10, 3'b101, 5'd11),
             32'hFFFF_FFFF);
        step("sltu_x12", r_op(7'h00, 5'd10, 5'd0, 3'b011, 5'd12), 32'd1);
        step("slt_x13",  r_op(7'h00, 5'd10, 5'd0, 3'b010, 5'd13), 32'd0);
        step("srli_neg", i_op({7'h00, 5'd28}, 5'd10, 3'b101, 5'd17),
             32'h0000_000F);
        step("sra_reg",  r_op(7'h20, 5'd5, 5'd10, 3'b101, 5'd18),
             32'hFFFF_FFFF);
        step("slti",     i_op(12'h000, 5'd10, 3'b010, 5'd19), 32'd1);
        step("sltiu",    i_op(12'hFFF, 5'd1, 3'b011, 5'd19), 32'd1);
        step("xori",     i_op(12'hFFF, 5'd1, 3'b100, 5'd20), 32'hFFFF_FFF5);
        step("ori",      i_op(12'h0F0, 5'd1, 3'b110, 5'd20), 32'h0000_00FA);
        step("andi",     i_op(12'h00C, 5'd3, 3'b111, 5'd20), 32'h0000_0004);
        step("sub_x14",  r_op(7'h20, 5'd3, 5'd1, 3'b000, 5'd14),
             32'hFFFF_FFF6);
        step("addi_33",  i_op(12'd33, 5'd0, 3'b000, 5'd22), 32'd33);
        step("sll_wrap", r_op(7'h00, 5'd22, 5'd1, 3'b001, 5'd21), 32'd20);
        step("sltu_rev", r_op(7'h00, 5'd0, 5'd10, 3'b011, 5'd23), 32'd0);
        step("bad_f7",   r_op(7'h20, 5'd3, 5'd1, 3'b001, 5'd24), 32'h0);
        step("bad_x24",  r_op(7'h00, 5'd0, 5'd24, 3'b000, 5'd25), 32'h0);

        step("x0_write", i_op(12'd5, 5'd0, 3'b000, 5'd0), 32'd5);
        step("x0_read",  r_op(7'h00, 5'd0, 5'd0, 3'b000, 5'd15), 32'd0);
        step("pre_rst",  32'h0011_01B3, 32'd20);

        #2;
        rst = 1'b0;
        #1;
        check("async_rst", 32'h0);
        @(negedge clk);
        rst = 1'b1;
        addr = 32'h0011_01B3;
        @(posedge clk);
        #1;
        check("post_rst_add", 32'h0);
        step("post_rst_x1", r_op(7'h00, 5'd0, 5'd1, 3'b000, 5'd26), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
